// File: rtl/sync_ram_fifo.sv
// Single-clock RAM-backed FIFO with registered output and registered status flags.
// Latency: a pop accepted on edge N presents its word on data_read with read_valid=1 after edge N.
// Backpressure: pushes while full are dropped unless a pop is accepted in the same cycle.
//
// Ports:
//   clk           sole clock, all logic on posedge
//   rst           synchronous active-high reset; clears pointers, count, flags and data_read
//   write_enable  push request, data_write carries the word
//   read_enable   pop request, word appears on data_read one cycle later with read_valid
//   full/empty/almost_full/almost_empty  registered occupancy flags
//   count         occupancy 0..DEPTH
//   overflow/underflow  sticky error flags, cleared only by rst
module sync_ram_fifo #(
  parameter int D_WIDTH       = 16,
  parameter int A_WIDTH       = 5,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_enable,
  input  logic [D_WIDTH-1:0] data_write,
  input  logic               read_enable,
  output logic [D_WIDTH-1:0] data_read,
  output logic               read_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [A_WIDTH:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int              DEPTH    = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] DEPTH_C  = (A_WIDTH + 1)'(DEPTH);
  localparam logic [A_WIDTH:0] AFULL_C  = (A_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [A_WIDTH:0] AEMPTY_C = (A_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [A_WIDTH:0] ONE_C    = (A_WIDTH + 1)'(1);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [A_WIDTH-1:0] wp;
  logic [A_WIDTH-1:0] rp;
  logic               pop_ok;
  logic               push_ok;
  logic [A_WIDTH:0]   count_nxt;

  // A pop frees a slot in the same edge, so a push against a full FIFO is
  // still accepted when paired with a pop. An empty FIFO never pops, so a
  // simultaneous push does not fall through to data_read.
  always_comb begin
    pop_ok    = read_enable && !empty;
    push_ok   = write_enable && (!full || pop_ok);
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // Storage is deliberately not reset; empty=1 after reset hides stale words.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wp] <= data_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      data_read    <= '0;
      read_valid   <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop_ok) begin
        data_read <= mem[rp];
        rp        <= rp + 1'b1;
      end
      read_valid <= pop_ok;
      count      <= count_nxt;
      // Flags come from the next-state count so they line up with count.
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      overflow     <= overflow  | (write_enable && full && !pop_ok);
      underflow    <= underflow | (read_enable && empty);
    end
  end

endmodule

// File: tb/tb_sync_ram_fifo.sv
// Bench for sync_ram_fifo: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based reference model of the FIFO.
module tb_sync_ram_fifo;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AFT   = 28;
  localparam int AET   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_enable = 1'b0;
  logic [DW-1:0] data_write = '0;
  logic          read_enable = 1'b0;
  logic [DW-1:0] data_read;
  logic          read_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sync_ram_fifo #(
    .D_WIDTH(DW), .A_WIDTH(AW), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .data_write(data_write),
    .read_enable(read_enable), .data_read(data_read), .read_valid(read_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd  = '0;
  logic          m_rv  = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare every output against the model.
  task automatic step(input logic r, input logic we, input logic [DW-1:0] wd, input logic re);
    int  sz;
    logic pop_ok;
    logic push_ok;
    rst          = r;
    write_enable = we;
    data_write   = wd;
    read_enable  = re;
    @(posedge clk);
    sz = q.size();
    if (r) begin
      q.delete();
      m_rd  = '0;
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = re && (sz > 0);
      push_ok = we && ((sz < DEPTH) || pop_ok);
      if (we && (sz == DEPTH) && !pop_ok) m_ovf = 1'b1;
      if (re && (sz == 0)) m_unf = 1'b1;
      m_rv = pop_ok;
      if (pop_ok) m_rd = q.pop_front();
      if (push_ok) q.push_back(wd);
    end
    #1;
    sz = q.size();
    chk("count",        32'(count),        32'(sz));
    chk("full",         32'(full),         32'(sz == DEPTH));
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("almost_full",  32'(almost_full),  32'(sz >= AFT));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AET));
    chk("read_valid",   32'(read_valid),   32'(m_rv));
    chk("data_read",    32'(data_read),    32'(m_rd));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_unf));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int occ;

    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Three pushes, three pops, consecutive outputs
    step(1'b0, 1'b1, 16'h1111, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 1'b0);
    step(1'b0, 1'b1, 16'h3333, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seq_d0", 32'(data_read), 32'h1111);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seq_d1", 32'(data_read), 32'h2222);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seq_d2", 32'(data_read), 32'h3333);
    chk("seq_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("seq_rv_drop", 32'(read_valid), 32'd0);
    chk("seq_hold", 32'(data_read), 32'h3333);

    // Fill to full, overflow, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 16'(i), 1'b0);
      if (i == AFT - 2) chk("afull_27", 32'(almost_full), 32'd0);
      if (i == AFT - 1) chk("afull_28", 32'(almost_full), 32'd1);
      if (i == DEPTH - 2) chk("full_31", 32'(full), 32'd0);
    end
    chk("full_32", 32'(full), 32'd1);
    step(1'b0, 1'b1, 16'hDEAD, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("drain_order", 32'(data_read), 32'(i));
    end

    // Push+pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 1'b1);
    chk("fullpp_count", 32'(count), 32'd32);
    chk("fullpp_full", 32'(full), 32'd1);
    chk("fullpp_oldest", 32'(data_read), 32'h0100);
    chk("fullpp_noovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("fullpp_last", 32'(data_read), 32'hBEEF);

    // Empty-side corner cases
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_rv", 32'(read_valid), 32'd0);
    do_reset();
    step(1'b0, 1'b1, 16'h5A5A, 1'b1);
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_rv", 32'(read_valid), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("emptypp_data", 32'(data_read), 32'h5A5A);

    // Steady-state streaming at occupancy 10 across pointer wrap
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 16'($urandom), 1'b1);
    chk("stream_occ", 32'(count), 32'd10);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
    step(1'b0, 1'b1, 16'h7777, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b1);
    chk("pre_rst_count", 32'(count), 32'd17);
    step(1'b1, 1'b1, 16'hAAAA, 1'b1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_rv", 32'(read_valid), 32'd0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    chk("resume_count", 32'(count), 32'd1);

    // Randomized traffic with drifting bias so both full and empty are hit
    for (int i = 0; i < 3000; i++) begin
      occ = (i / 300) % 2;
      d = 16'($urandom);
      if ($urandom_range(0, 299) == 0)
        step(1'b1, 1'($urandom), d, 1'($urandom));
      else if (occ == 0)
        step(1'b0, $urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 4);
      else
        step(1'b0, $urandom_range(0, 9) < 4, d, $urandom_range(0, 9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_ram_fifo.md
SYNC_RAM_FIFO -- requirements
Module: sync_ram_fifo

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter A_WIDTH, default 5, address width; depth DEPTH = 2**A_WIDTH words.
REQ-003 SHALL have parameter AFULL_THRESH, default 28, almost_full asserts when count >= AFULL_THRESH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 SHALL use one clock and synchronous active-high reset: clk  input  1  sole clock, all logic on posedge.
REQ-006 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port: write_enable  input  1  push request.
REQ-008 SHALL have port: data_write  input  D_WIDTH  push data.
REQ-009 SHALL have port: read_enable  input  1  pop request.
REQ-010 SHALL have port: data_read  output  D_WIDTH  popped word, registered.
REQ-011 SHALL have port: read_valid  output  1  data_read holds a word popped on the previous cycle.
REQ-012 SHALL have ports: full, empty, almost_full, almost_empty  output  1 each  registered status flags.
REQ-013 SHALL have port: count  output  A_WIDTH+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have ports: overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL store data in an internal DEPTH x D_WIDTH array with write pointer wp and read pointer rp, each A_WIDTH bits, wrapping DEPTH-1 -> 0.
REQ-016 SHALL accept a push when write_enable=1 and (full=0 or an accepted pop occurs in the same cycle): mem[wp] <= data_write, wp++.
REQ-017 SHALL accept a pop when read_enable=1 and empty=0: data_read <= mem[rp], rp++, read_valid=1 next cycle.
REQ-018 SHALL deassert read_valid the cycle after any cycle with no accepted pop; data_read holds its last value then.
REQ-019 SHALL give read latency exactly 1 cycle: word available on data_read the clock after the accepting edge.
REQ-020 SHALL, on write_enable while empty=1 together with read_enable, accept only the push (no fall-through); read_valid stays 0.
REQ-021 SHALL, on simultaneous accepted push and pop (full included), leave count unchanged and advance both pointers.
REQ-022 SHALL update count: +1 push only, -1 pop only, unchanged otherwise; never exceed DEPTH nor drop below 0.
REQ-023 SHALL derive all flags from next-state count so they are valid in the cycle after the causing edge: full=(count==DEPTH), empty=(count==0).
REQ-024 SHALL set overflow (sticky) on write_enable=1 while full=1 and no accepted pop; the push is discarded, no state change.
REQ-025 SHALL set underflow (sticky) on read_enable=1 while empty=1; the pop is ignored, data_read unchanged.
REQ-026 SHALL preserve FIFO order across pointer wrap-around with no lost or duplicated words.

Reset
REQ-027 SHALL, while rst=1 at posedge clk, set wp=rp=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, read_valid=0, data_read=0, overflow=0, underflow=0.
REQ-028 SHALL give rst priority over write_enable/read_enable in the same cycle; reset mid-operation discards all stored words.
REQ-029 SHALL NOT reset array contents; no read can observe stale data since empty=1 after reset.
REQ-030 SHALL resume normal operation on the first edge after rst deasserts.

Verification (D_WIDTH=16, A_WIDTH=5, AFULL_THRESH=28, AEMPTY_THRESH=4)
REQ-031 SHALL cover: reset, push 0x1111, 0x2222, 0x3333, then pop 3 -> data_read 0x1111, 0x2222, 0x3333 on consecutive cycles with read_valid=1, then empty=1, count=0.
REQ-032 SHALL cover: push 32 words 0x0000..0x001F -> almost_full=1 at count=28, full=1 at count=32; 33rd push -> overflow=1, count stays 32; pop all -> 0x0000..0x001F in order.
REQ-033 SHALL cover: at full, push 0xBEEF with simultaneous pop -> count stays 32, full stays 1, popped word is oldest, 0xBEEF read last.
REQ-034 SHALL cover: pop on empty -> underflow=1, read_valid=0; push+pop on empty -> count=1, read_valid=0 next cycle.
REQ-035 SHALL cover: 100 push/pop cycles with pointer wrap (occupancy 10) -> output sequence equals input sequence.
REQ-036 SHALL cover: rst asserted with count=17 and push+pop active -> next cycle count=0, empty=1, read_valid=0, overflow=underflow=0.
